rtc_lect_bus: RTL and testbench
===============================

Name: rtc_lect_bus

Overview:
- Read-side counterpart of the RTC address/data driver. Sweeps the nine RTC time, date and timer registers, one read cycle each, and captures the byte returned on the multiplexed bus.
- Commits all nine bytes atomically to output registers, so the display and config logic never see a torn time.
- Sits between the RTC bus timing controller (which runs the physical read strobes) and the clock/date/timer display datapath.

Parameters:
- TO_CYC, 255, max clk cycles to wait for bus_done per read before abort (8-bit counter, 1..255)

Ports:
- clk  in  1  system clock, all logic on rising edge
- clr  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse: begin a read sweep; ignored while busy
- bus_done  in  1  one-cycle pulse from bus controller: current read cycle complete, ad_in valid this cycle
- ad_in  in  8  byte read from RTC bus
- rd_req  out  1  request a read cycle at rd_adr; held until bus_done
- rd_adr  out  8  RTC register address for the current read
- busy  out  1  high from the cycle after an accepted start until the sweep ends
- done  out  1  one-cycle pulse: sweep committed
- err_to  out  1  one-cycle pulse: sweep aborted on timeout
- bcd_err  out  1  level: last committed sweep held a nibble > 9; cleared on next accepted start
- r_h_s, r_h_m, r_h_h  out  8 each  clock seconds, minutes, hours
- r_f_d, r_f_m, r_f_a  out  8 each  date day, month, year
- r_t_s, r_t_m, r_t_h  out  8 each  timer seconds, minutes, hours

Behaviour:
- Reset: clr=1 asynchronously clears all outputs and internal state to 0; FSM goes to IDLE, idx=0, timeout counter=0.
- Address table by idx 0..8: 0x21, 0x22, 0x23, 0x24, 0x25, 0x26, 0x41, 0x42, 0x43.
  - Shadow mapping in the same order: h_s, h_m, h_h, f_d, f_m, f_a, t_s, t_m, t_h.
- rd_adr is the table entry for idx while busy, and 0x00 in IDLE.
- FSM states: IDLE, REQ, GAP, COMMIT.
- IDLE:
  - start=1: next state REQ, idx←0, bcd_err←0, timeout counter←0.
  - bus_done is ignored in IDLE.
- REQ:
  - rd_req=1.
  - bus_done=1: shadow[idx]←ad_in. If idx=8, go to COMMIT; otherwise go to GAP with idx←idx+1. Timeout counter←0.
  - bus_done=0: counter increments. When the counter reaches TO_CYC without bus_done: err_to pulses, state returns to IDLE, and outputs keep their previous committed values (shadow is discarded).
  - bus_done in the same cycle the counter reaches TO_CYC: bus_done wins.
- GAP: rd_req=0 for exactly one cycle, then REQ. bus_done in GAP is ignored.
- COMMIT: one cycle.
  - All nine output registers load from shadow.
  - bcd_err←1 if any nibble of any shadow byte > 9.
  - done=1 this cycle, then IDLE.
- busy=1 in REQ, GAP and COMMIT.
- start is ignored in every non-IDLE state.
- Latency:
  - start at edge k → rd_req=1, rd_adr=0x21 after edge k+1.
  - Each element takes ≥2 cycles (REQ ≥1, GAP 1).
  - With bus_done arriving in the first REQ cycle every time, a full sweep is 9 REQ + 8 GAP + 1 COMMIT = 18 cycles after start.
- Outputs change only in COMMIT or on reset. Partial sweeps are never visible.
- clr mid-sweep: immediate return to IDLE; outputs zeroed, no done/err_to pulse.
- ad_in is sampled only in REQ with bus_done=1. It carries raw bytes; no masking or BCD conversion.

Test Plan:
- Reset then idle:
  - Stimulus: clr pulse, no start.
  - Required: all r_* = 0x00, rd_req=0, rd_adr=0x00, busy=0, done=0 for 20 cycles.
- Full sweep, immediate bus_done:
  - Stimulus: start; bus_done on the first REQ cycle of each element, ad_in = 0x45, 0x30, 0x12, 0x11, 0x05, 0x17, 0x10, 0x02, 0x00.
  - Required: rd_adr sequence 21, 22, 23, 24, 25, 26, 41, 42, 43; done 18 cycles after start; r_h_s=0x45, r_h_m=0x30, r_h_h=0x12, r_f_d=0x11, r_f_m=0x05, r_f_a=0x17, r_t_s=0x10, r_t_m=0x02, r_t_h=0x00; bcd_err=0.
- Slow bus plus atomicity:
  - Stimulus: bus_done delayed 7 cycles per element.
  - Required: rd_req held high throughout each wait; r_* unchanged until the COMMIT cycle, then all update together.
- Timeout:
  - Stimulus: TO_CYC=16; complete 3 reads, then withhold bus_done at rd_adr=0x24.
  - Required: err_to pulses after 16 cycles; busy=0; r_* retain prior sweep values; done never asserts.
- BCD error plus start while busy:
  - Stimulus: sweep with ad_in=0x3A for 0x22; a second start pulse mid-sweep.
  - Required: second start ignored (single sweep, single done); r_h_m=0x3A; bcd_err=1, cleared on the next accepted start.
- Reset mid-sweep:
  - Stimulus: clr asserted at idx=5.
  - Required: all r_*=0, rd_req=0, busy=0, no done; a new start runs a clean sweep from 0x21.

Source files
------------

// File: rtl/rtc_lect_bus.sv
// Reads the nine RTC time/date/timer registers in one sweep and commits them atomically.
// Latency: 9 REQ + 8 GAP + 1 COMMIT cycles minimum; done/err_to and r_* update on the edge leaving COMMIT/abort.
// Backpressure: each REQ holds rd_req until bus_done, aborting after TO_CYC idle cycles; start ignored while busy.
module rtc_lect_bus #(
    parameter int TO_CYC = 255
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic       bus_done,
    input  logic [7:0] ad_in,
    output logic       rd_req,
    output logic [7:0] rd_adr,
    output logic       busy,
    output logic       done,
    output logic       err_to,
    output logic       bcd_err,
    output logic [7:0] r_h_s,
    output logic [7:0] r_h_m,
    output logic [7:0] r_h_h,
    output logic [7:0] r_f_d,
    output logic [7:0] r_f_m,
    output logic [7:0] r_f_a,
    output logic [7:0] r_t_s,
    output logic [7:0] r_t_m,
    output logic [7:0] r_t_h
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REQ    = 2'd1;
    localparam logic [1:0] S_GAP    = 2'd2;
    localparam logic [1:0] S_COMMIT = 2'd3;
    localparam logic [7:0] TO_LIM   = 8'(TO_CYC);
    localparam logic [3:0] IDX_LAST = 4'd8;

    logic [1:0]      state_q, state_d;
    logic [3:0]      idx_q, idx_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [8:0][7:0] shd_q;
    logic [8:0][7:0] out_q;
    logic            done_q, err_to_q, bcd_err_q;
    logic            shd_we, commit, abort, clr_bcd, bcd_bad;

    function automatic logic [7:0] adr_of(input logic [3:0] idx);
        case (idx)
            4'd0:    adr_of = 8'h21;
            4'd1:    adr_of = 8'h22;
            4'd2:    adr_of = 8'h23;
            4'd3:    adr_of = 8'h24;
            4'd4:    adr_of = 8'h25;
            4'd5:    adr_of = 8'h26;
            4'd6:    adr_of = 8'h41;
            4'd7:    adr_of = 8'h42;
            default: adr_of = 8'h43;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        shd_we  = 1'b0;
        commit  = 1'b0;
        abort   = 1'b0;
        clr_bcd = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_REQ;
                    idx_d   = 4'd0;
                    cnt_d   = 8'd0;
                    clr_bcd = 1'b1;
                end
            end
            S_REQ: begin
                // a bus_done landing on the limit cycle still counts as a good read
                if (bus_done) begin
                    shd_we = 1'b1;
                    cnt_d  = 8'd0;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_COMMIT;
                    end else begin
                        state_d = S_GAP;
                        idx_d   = idx_q + 4'd1;
                    end
                end else if (cnt_q == TO_LIM) begin
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                    abort   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_GAP: begin
                state_d = S_REQ;
            end
            default: begin
                commit  = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        bcd_bad = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if ((shd_q[i][3:0] > 4'd9) || (shd_q[i][7:4] > 4'd9)) begin
                bcd_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= S_IDLE;
            idx_q     <= 4'd0;
            cnt_q     <= 8'd0;
            shd_q     <= '0;
            out_q     <= '0;
            done_q    <= 1'b0;
            err_to_q  <= 1'b0;
            bcd_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            done_q   <= commit;
            err_to_q <= abort;
            for (int i = 0; i < 9; i++) begin
                if (shd_we && (idx_q == 4'(i))) begin
                    shd_q[i] <= ad_in;
                end
            end
            if (commit) begin
                out_q     <= shd_q;
                bcd_err_q <= bcd_bad;
            end else if (clr_bcd) begin
                bcd_err_q <= 1'b0;
            end
        end
    end

    assign rd_req  = (state_q == S_REQ);
    assign rd_adr  = (state_q == S_IDLE) ? 8'h00 : adr_of(idx_q);
    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign err_to  = err_to_q;
    assign bcd_err = bcd_err_q;

    assign r_h_s = out_q[0];
    assign r_h_m = out_q[1];
    assign r_h_h = out_q[2];
    assign r_f_d = out_q[3];
    assign r_f_m = out_q[4];
    assign r_f_a = out_q[5];
    assign r_t_s = out_q[6];
    assign r_t_m = out_q[7];
    assign r_t_h = out_q[8];

endmodule

// File: tb/tb_rtc_lect_bus.sv
// Bench for rtc_lect_bus: a reactive bus-controller model driving randomized sweeps,
// compared against a sweep-level reference of committed registers and bcd status.
module tb_rtc_lect_bus;

    localparam int TO = 16;

    typedef logic [7:0] b9_t [9];
    typedef int         i9_t [9];

    logic       clk = 1'b0;
    logic       clr, start, bus_done;
    logic [7:0] ad_in;
    logic       rd_req, busy, done, err_to, bcd_err;
    logic [7:0] rd_adr;
    logic [7:0] r_h_s, r_h_m, r_h_h, r_f_d, r_f_m, r_f_a, r_t_s, r_t_m, r_t_h;

    always #5 clk = ~clk;

    rtc_lect_bus #(.TO_CYC(TO)) dut (
        .clk(clk), .clr(clr), .start(start), .bus_done(bus_done), .ad_in(ad_in),
        .rd_req(rd_req), .rd_adr(rd_adr), .busy(busy), .done(done), .err_to(err_to),
        .bcd_err(bcd_err),
        .r_h_s(r_h_s), .r_h_m(r_h_m), .r_h_h(r_h_h),
        .r_f_d(r_f_d), .r_f_m(r_f_m), .r_f_a(r_f_a),
        .r_t_s(r_t_s), .r_t_m(r_t_m), .r_t_h(r_t_h)
    );

    wire [71:0] r_all = {r_t_h, r_t_m, r_t_s, r_f_a, r_f_m, r_f_d, r_h_h, r_h_m, r_h_s};

    int   n_chk = 0;
    int   n_err = 0;
    b9_t  mdl_r;
    logic mdl_bcd;
    b9_t  adr_tab;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [71:0] pack9(input b9_t d);
        pack9 = {d[8], d[7], d[6], d[5], d[4], d[3], d[2], d[1], d[0]};
    endfunction

    function automatic logic bcd_bad(input b9_t d);
        bcd_bad = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if ((d[i] % 16) > 9 || (d[i] / 16) > 9) bcd_bad = 1'b1;
        end
    endfunction

    task automatic idle_cycles(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            chk({tag, ".rd_req"}, 72'(rd_req), 72'd0);
            chk({tag, ".rd_adr"}, 72'(rd_adr), 72'd0);
            chk({tag, ".busy"}, 72'(busy), 72'd0);
            chk({tag, ".pulses"}, 72'({done, err_to}), 72'd0);
            chk({tag, ".r_all"}, r_all, pack9(mdl_r));
            chk({tag, ".bcd_err"}, 72'(bcd_err), 72'(mdl_bcd));
            bus_done = 1'($urandom_range(0, 1));
            ad_in    = 8'($urandom);
            @(negedge clk);
            bus_done = 1'b0;
        end
    endtask

    // One sweep: dly[i] is how many REQ cycles pass before bus_done for element i.
    task automatic run_sweep(input b9_t dat, input i9_t dly, input bit mid_start, input int clr_idx);
        int c;
        int edges;
        int exp_edges;
        exp_edges = 9;
        for (int i = 0; i < 9; i++) exp_edges += dly[i] + 1;
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        edges   = 0;
        mdl_bcd = 1'b0;
        chk("bcd_clr_on_start", 72'(bcd_err), 72'(mdl_bcd));
        for (int i = 0; i < 9; i++) begin
            c = 0;
            if (i == clr_idx) begin
                clr = 1'b1;
                #1;
                mdl_r   = '{default: 8'h00};
                mdl_bcd = 1'b0;
                chk("clr.r_all", r_all, pack9(mdl_r));
                chk("clr.rd_req", 72'(rd_req), 72'd0);
                chk("clr.busy", 72'(busy), 72'd0);
                chk("clr.pulses", 72'({done, err_to, bcd_err}), 72'd0);
                @(negedge clk);
                clr = 1'b0;
                return;
            end
            forever begin
                chk($sformatf("req%0d.rd_req", i), 72'(rd_req), 72'd1);
                chk($sformatf("req%0d.rd_adr", i), 72'(rd_adr), 72'(adr_tab[i]));
                chk($sformatf("req%0d.busy", i), 72'(busy), 72'd1);
                chk($sformatf("req%0d.pulses", i), 72'({done, err_to}), 72'd0);
                chk($sformatf("req%0d.r_all", i), r_all, pack9(mdl_r));
                bus_done = (c == dly[i]);
                ad_in    = (c == dly[i]) ? dat[i] : 8'($urandom);
                start    = mid_start && (i == 4) && (c == 0);
                @(negedge clk);
                edges++;
                bus_done = 1'b0;
                start    = 1'b0;
                if (c == dly[i]) break;
                if (c == TO) begin
                    chk("timeout.err_to", 72'(err_to), 72'd1);
                    chk("timeout.busy", 72'(busy), 72'd0);
                    chk("timeout.rd_req", 72'(rd_req), 72'd0);
                    chk("timeout.done", 72'(done), 72'd0);
                    chk("timeout.r_all", r_all, pack9(mdl_r));
                    @(negedge clk);
                    chk("timeout.err_to_pulse", 72'(err_to), 72'd0);
                    return;
                end
                c++;
            end
            if (i < 8) begin
                chk($sformatf("gap%0d.rd_req", i), 72'(rd_req), 72'd0);
                chk($sformatf("gap%0d.busy", i), 72'(busy), 72'd1);
                chk($sformatf("gap%0d.rd_adr", i), 72'(rd_adr), 72'(adr_tab[i+1]));
                bus_done = 1'($urandom_range(0, 1));
                ad_in    = 8'($urandom);
                @(negedge clk);
                edges++;
                bus_done = 1'b0;
            end
        end
        chk("commit.busy", 72'(busy), 72'd1);
        chk("commit.rd_req", 72'(rd_req), 72'd0);
        chk("commit.r_all_old", r_all, pack9(mdl_r));
        @(negedge clk);
        edges++;
        mdl_r   = dat;
        mdl_bcd = bcd_bad(dat);
        chk("done", 72'(done), 72'd1);
        chk("done.latency", 72'(edges), 72'(exp_edges));
        chk("done.r_all", r_all, pack9(mdl_r));
        chk("done.bcd_err", 72'(bcd_err), 72'(mdl_bcd));
        chk("done.busy", 72'(busy), 72'd0);
        @(negedge clk);
        chk("done.pulse", 72'({done, err_to}), 72'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        b9_t dat;
        i9_t dly;
        adr_tab  = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
        mdl_r    = '{default: 8'h00};
        mdl_bcd  = 1'b0;
        clr      = 1'b1;
        start    = 1'b0;
        bus_done = 1'b0;
        ad_in    = 8'h00;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        idle_cycles(20, "reset_idle");

        dat = '{8'h45, 8'h30, 8'h12, 8'h11, 8'h05, 8'h17, 8'h10, 8'h02, 8'h00};
        dly = '{default: 0};
        run_sweep(dat, dly, 1'b0, -1);
        idle_cycles(2, "after_full");

        for (int i = 0; i < 9; i++) dat[i] = 8'($urandom);
        dly = '{default: 7};
        run_sweep(dat, dly, 1'b0, -1);
        idle_cycles(2, "after_slow");

        for (int i = 0; i < 9; i++) dat[i] = 8'($urandom);
        dly    = '{default: 0};
        dly[3] = TO + 1;
        run_sweep(dat, dly, 1'b0, -1);
        idle_cycles(3, "after_timeout");

        for (int i = 0; i < 9; i++) dat[i] = 8'($urandom_range(0, 9) * 16 + $urandom_range(0, 9));
        dly    = '{default: 1};
        dly[2] = TO;
        run_sweep(dat, dly, 1'b0, -1);
        idle_cycles(2, "after_limit");

        dat    = '{8'h01, 8'h3A, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        dly    = '{default: 0};
        dly[4] = 2;
        run_sweep(dat, dly, 1'b1, -1);
        idle_cycles(3, "after_bcd");

        for (int s = 0; s < 6; s++) begin
            for (int i = 0; i < 9; i++) begin
                dat[i] = (s % 2 == 0) ? 8'($urandom)
                                      : 8'($urandom_range(0, 9) * 16 + $urandom_range(0, 9));
                dly[i] = $urandom_range(0, 3);
            end
            run_sweep(dat, dly, 1'($urandom_range(0, 1)), -1);
            idle_cycles(1, "after_rand");
        end

        for (int i = 0; i < 9; i++) dat[i] = 8'($urandom);
        dly = '{default: 1};
        run_sweep(dat, dly, 1'b0, 5);
        idle_cycles(3, "after_clr");
        dat = '{8'h59, 8'h59, 8'h23, 8'h31, 8'h12, 8'h99, 8'h00, 8'h00, 8'h01};
        dly = '{default: 0};
        run_sweep(dat, dly, 1'b0, -1);
        idle_cycles(2, "final");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
